// File: rtl/seq_sort_network.sv
// seq_sort_network: clocked odd-even transposition sorter for N unsigned W-bit
// elements, ascending or descending per job, one compare-exchange phase per clock.
// A job latches its input on the accepting edge. The result appears on o together
// with a one-cycle done pulse N edges later, and o holds that result until the
// next job finishes.
module seq_sort_network #(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           desc,
  input  logic [N*W-1:0] i,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] o
);

  localparam logic [CW-1:0] LAST_PHASE = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [N-1:0][W-1:0]     r_a;
  logic [N-1:0][W-1:0]     w_a_nxt;
  logic [CW-1:0]           r_phase;
  logic                    r_desc;
  logic                    r_done;
  logic                    r_busy;
  logic                    r_ready;
  logic [N*W-1:0]          r_o;
  logic                    w_load;
  logic                    w_last;
  logic [N-2:0]            w_swap;

  // Pair (j, j+1) is active when its parity matches the phase parity; an active
  // pair swaps when it is out of order for the selected direction (ties never swap).
  for (genvar j = 0; j < N - 1; j++) begin : g_cmp
    localparam logic JPAR = 1'(j % 2);
    assign w_swap[j] = (r_phase[0] == JPAR) &&
                       (r_desc ? (r_a[j] < r_a[j+1]) : (r_a[j] > r_a[j+1]));
  end

  // Each element takes its left or right neighbour when the pair it belongs to
  // swaps; active pairs in one phase never overlap, so at most one select fires.
  // For odd N the unpaired end element falls through unchanged.
  for (genvar k = 0; k < N; k++) begin : g_sel
    if (k == 0) begin : g_first
      assign w_a_nxt[k] = w_swap[k] ? r_a[k+1] : r_a[k];
    end else if (k == N - 1) begin : g_last
      assign w_a_nxt[k] = w_swap[k-1] ? r_a[k-1] : r_a[k];
    end else begin : g_mid
      assign w_a_nxt[k] = w_swap[k-1] ? r_a[k-1] :
                          (w_swap[k] ? r_a[k+1] : r_a[k]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, plus the load and final-phase strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SORT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SORT: begin
        if (r_phase == LAST_PHASE) begin
          w_state_nxt = S_DONE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = S_SORT;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_SORT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Working array, latched direction and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_desc  <= 1'b0;
      r_phase <= '0;
    end else if (w_load) begin
      r_a     <= i;
      r_desc  <= desc;
      r_phase <= '0;
    end else if (r_state == S_SORT) begin
      r_a     <= w_a_nxt;
      r_phase <= r_phase + CW'(1);
    end else begin
      r_a     <= r_a;
      r_desc  <= r_desc;
      r_phase <= r_phase;
    end
  end

  // Registered outputs: o updates only on the final phase; flags follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (w_last) begin
        r_o <= w_a_nxt;
      end else begin
        r_o <= r_o;
      end
      r_done  <= w_last;
      r_busy  <= (w_state_nxt == S_SORT);
      r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
    end
  end

  assign o     = r_o;
  assign done  = r_done;
  assign busy  = r_busy;
  assign ready = r_ready;

endmodule

// File: tb/tb_seq_sort_network.sv
// Scoreboard bench for seq_sort_network: a 4x4-bit instance and a 5x8-bit instance
// share clock and reset. Stimulus pushes the expected result and the expected done
// cycle for each job, and a per-instance monitor pops and compares on every done pulse.
module tb_seq_sort_network;

  logic        clk;
  logic        rst = 1'b0;
  logic        start4 = 1'b0, desc4 = 1'b0;
  logic [15:0] i4 = '0;
  logic        ready4, busy4, done4;
  logic [15:0] o4;
  logic        start5 = 1'b0, desc5 = 1'b0;
  logic [39:0] i5 = '0;
  logic        ready5, busy5, done5;
  logic [39:0] o5;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  seq_sort_network #(.W(4), .N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .desc(desc4), .i(i4),
    .ready(ready4), .busy(busy4), .done(done4), .o(o4)
  );

  seq_sort_network #(.W(8), .N(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .desc(desc5), .i(i5),
    .ready(ready5), .busy(busy5), .done(done5), .o(o5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; a job issued when cyc==k finishes when cyc==k+1+N.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unpack the elements, sort them with an insertion sort, repack.
  function automatic logic [63:0] model(input logic [63:0] v, input int n, input int w, input bit d);
    int unsigned e[8];
    int unsigned t;
    logic [63:0] r;
    for (int k = 0; k < n; k++) e[k] = 32'((v >> (k * w)) & ((64'd1 << w) - 64'd1));
    for (int a = 1; a < n; a++) begin
      for (int b = a; b > 0; b--) begin
        if (d ? (e[b-1] < e[b]) : (e[b-1] > e[b])) begin
          t = e[b-1]; e[b-1] = e[b]; e[b] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < n; k++) r = r | (64'(e[k]) << (k * w));
    return r;
  endfunction

  // Monitor for the 4x4 instance.
  initial begin
    logic [15:0] prev;
    logic        pd;
    exp_t        e;
    prev = '0;
    pd   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = o4;
        pd   = 1'b0;
      end else begin
        if (done4) begin
          if (q4.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut4 unexpected done: got o=%0h, expected no done", o4);
          end else begin
            e = q4.pop_front();
            check("dut4 result", 64'(o4), e.data);
            check("dut4 done cycle", 64'(cyc), 64'(e.cyc));
          end
          check("dut4 done/ready/busy", {61'd0, pd, ready4, busy4}, 64'b010);
        end else begin
          check("dut4 o hold", 64'(o4), 64'(prev));
        end
        prev = o4;
        pd   = done4;
      end
    end
  end

  // Monitor for the 5x8 instance.
  initial begin
    logic [39:0] prev;
    logic        pd;
    exp_t        e;
    prev = '0;
    pd   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = o5;
        pd   = 1'b0;
      end else begin
        if (done5) begin
          if (q5.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut5 unexpected done: got o=%0h, expected no done", o5);
          end else begin
            e = q5.pop_front();
            check("dut5 result", 64'(o5), e.data);
            check("dut5 done cycle", 64'(cyc), 64'(e.cyc));
          end
          check("dut5 done/ready/busy", {61'd0, pd, ready5, busy5}, 64'b010);
        end else begin
          check("dut5 o hold", 64'(o5), 64'(prev));
        end
        prev = o5;
        pd   = done5;
      end
    end
  end

  // Issue one job to the 4x4 instance (call at a falling edge); checks busy for N cycles.
  // With poke set, a start with junk data is pulsed mid-sort and must be ignored.
  task automatic issue4(input logic [15:0] din, input bit d, input logic [63:0] ev, input bit poke);
    int t = 0;
    while (!ready4 && t < 40) begin @(negedge clk); t++; end
    check("dut4 ready before start", 64'(ready4), 64'd1);
    if (ready4) begin
      i4 = din; desc4 = d; start4 = 1'b1;
      q4.push_back('{data: ev, cyc: cyc + 4 + 1});
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start4 = poke && (k == 1);
        i4     = 16'($urandom);
        desc4  = 1'($urandom);
        check("dut4 busy during sort", {62'd0, busy4, ready4}, 64'b10);
      end
      start4 = 1'b0;
    end
  endtask

  // Issue one job to the 5x8 instance; same contract as issue4.
  task automatic issue5(input logic [39:0] din, input bit d, input logic [63:0] ev, input bit poke);
    int t = 0;
    while (!ready5 && t < 40) begin @(negedge clk); t++; end
    check("dut5 ready before start", 64'(ready5), 64'd1);
    if (ready5) begin
      i5 = din; desc5 = d; start5 = 1'b1;
      q5.push_back('{data: ev, cyc: cyc + 5 + 1});
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        start5 = poke && (k == 1);
        i5     = {8'($urandom), 32'($urandom)};
        desc5  = 1'($urandom);
        check("dut5 busy during sort", {62'd0, busy5, ready5}, 64'b10);
      end
      start5 = 1'b0;
    end
  endtask

  // Assert reset now (mid-clock), check the reset values at once, drop pending jobs.
  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    check("dut4 reset outputs", {45'd0, o4, ready4, busy4, done4}, 64'b100);
    check("dut5 reset outputs", {21'd0, o5, ready5, busy5, done5}, 64'b100);
    q4.delete();
    q5.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((q4.size() != 0 || q5.size() != 0) && t < 100) begin @(negedge clk); t++; end
    check("scoreboard drained", 64'(q4.size() + q5.size()), 64'd0);
  endtask

  task automatic rand4(input int cnt);
    logic [15:0] v;
    bit          d;
    for (int n = 0; n < cnt; n++) begin
      v = 16'($urandom);
      if (n % 3 == 0) v = {2{v[7:0]}};
      d = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue4(v, d, model(64'(v), 4, 4, d), (n % 4) == 0);
    end
  endtask

  task automatic rand5(input int cnt);
    logic [39:0] v;
    bit          d;
    for (int n = 0; n < cnt; n++) begin
      for (int k = 0; k < 5; k++) begin
        v[k*8 +: 8] = (n % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      d = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue5(v, d, model(64'(v), 5, 8, d), (n % 4) == 1);
    end
  endtask

  initial begin
    @(posedge clk);
    #2;
    pulse_rst();

    // Idle with start low: nothing moves.
    repeat (10) begin
      @(negedge clk);
      check("dut4 idle hold", {45'd0, o4, ready4, busy4, done4}, 64'b100);
    end

    // Directed 4x4 jobs, issued back to back.
    issue4(16'h3A1F, 1'b0, 64'hFA31, 1'b0);
    issue4(16'h3A1F, 1'b1, 64'h13AF, 1'b1);
    issue4(16'h5555, 1'b1, 64'h5555, 1'b0);
    issue4(16'h0F0F, 1'b0, 64'hFF00, 1'b0);

    // Odd N worst case: e0=50 .. e4=10, then the same input descending.
    issue5(40'h0A141E2832, 1'b0, 64'h32281E140A, 1'b0);
    issue5(40'h0A141E2832, 1'b1, 64'h0A141E2832, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    // Reset two edges into a job: no done, o cleared.
    i4 = 16'hC4B2; desc4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    pulse_rst();
    repeat (6) @(negedge clk);
    issue4(16'hC4B2, 1'b0, 64'hCB42, 1'b0);
    drain();

    // Randomised jobs on both instances concurrently.
    fork
      rand4(30);
      rand5(30);
    join
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
